// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the PDM microphone front end.
//   state_t   : capture controller states (IDLE / SETTLE / CAPTURE)
//   PDM_POS   : sample code for a captured 1 (+1)
//   PDM_NEG   : sample code for a captured 0 (-1)
//   cnt_width : counter width able to hold 0..n-1 (never below 1 bit)
//   pdm_code  : maps a raw microphone bit onto its sample code
// The decimator imports the same codes so both ends agree on the encoding.
// -----------------------------------------------------------------------------
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] PDM_POS = 2'b01;
    localparam logic [1:0] PDM_NEG = 2'b11;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] pdm_code(input logic bit_i);
        return bit_i ? PDM_POS : PDM_NEG;
    endfunction

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl_if
// Sample stream from the capture controller to the CIC/CNN feature path.
//   pdm_o      : sample code (PDM_POS / PDM_NEG), holds between pulses
//   pdm_valid  : one-cycle pulse per captured sample
//   frame_last : high with pdm_valid on the final sample of a frame
//   pdm_ready  : consumer can accept; only observed, never stalls capture
// master = capture controller, slave = downstream consumer.
// -----------------------------------------------------------------------------
interface pdm_capture_ctrl_if;

    logic [1:0] pdm_o;
    logic       pdm_valid;
    logic       frame_last;
    logic       pdm_ready;

    modport master (
        output pdm_o,
        output pdm_valid,
        output frame_last,
        input  pdm_ready
    );

    modport slave (
        input  pdm_o,
        input  pdm_valid,
        input  frame_last,
        output pdm_ready
    );

endinterface

// File: rtl/pdm_clk_div.sv
// -----------------------------------------------------------------------------
// pdm_clk_div
// Divides clk down to the microphone bit clock. micro_clk toggles every
// CLK_DIV clk cycles, giving a 2*CLK_DIV period at 50% duty.
//   clk, rst  : system clock, asynchronous active-high reset
//   en        : low forces the count and micro_clk to 0 on the next edge
//   micro_clk : registered bit clock
//   pre_rise  : high in the clk cycle before micro_clk rises
//   pre_fall  : high in the clk cycle before micro_clk falls
// The strobes are decoded from register state only (not from en), so the
// controller may derive en from its own next-state logic without forming a
// combinational loop. With CLK_DIV >= 2 a cleared divider never strobes.
// -----------------------------------------------------------------------------
module pdm_clk_div
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic micro_clk,
    output logic pre_rise,
    output logic pre_fall
);

    localparam int            CW       = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          micro_clk_q, micro_clk_d;
    logic          at_last;

    assign at_last = (cnt_q == CNT_LAST);

    // NOTE: every signal written in an always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        micro_clk_d = micro_clk_q;
        if (!en) begin
            cnt_d       = '0;
            micro_clk_d = 1'b0;
        end else if (at_last) begin
            cnt_d       = '0;
            micro_clk_d = ~micro_clk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            micro_clk_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            micro_clk_q <= micro_clk_d;
        end
    end

    assign micro_clk = micro_clk_q;
    assign pre_rise  = at_last & ~micro_clk_q;
    assign pre_fall  = at_last &  micro_clk_q;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl
// Sequencing controller for the PDM microphone front end. Sleeps the mic in
// IDLE (micro_clk held low), discards SETTLE_CYC bit-clock periods after wake
// or channel change, then emits one +/-1 sample code per bit-clock period in
// frames of FRAME_LEN samples. Stop and channel-change requests made while
// capturing are deferred to the frame boundary.
//   clk, rst    : system clock, asynchronous active-high reset
//   start       : one-cycle request to begin capture (honoured in IDLE only)
//   stop        : one-cycle request to end capture
//   set_sel_i   : requested channel, 0 = left, 1 = right
//   set_sel_val : qualifies set_sel_i
//   micro_pdm_i : microphone data, already synchronised to clk
//   pdm_bus     : sample stream (pdm_o / pdm_valid / frame_last / pdm_ready)
//   micro_clk   : registered microphone bit clock
//   sel_lr      : channel select to the microphone
//   busy        : high in any state other than IDLE
//   overrun     : sticky, a sample was presented while pdm_ready was low
// -----------------------------------------------------------------------------
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int SETTLE_CYC = 1024,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       set_sel_i,
    input  logic                       set_sel_val,
    input  logic                       micro_pdm_i,
    pdm_capture_ctrl_if.master         pdm_bus,
    output logic                       micro_clk,
    output logic                       sel_lr,
    output logic                       busy,
    output logic                       overrun
);

    localparam int            SW          = cnt_width(SETTLE_CYC);
    localparam int            FW          = cnt_width(FRAME_LEN);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_LEN - 1);

    state_t        state_q, state_d;
    logic          sel_lr_q, sel_lr_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [FW-1:0] sample_cnt_q, sample_cnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic          sel_pend_q, sel_pend_d;
    logic          sel_req_q, sel_req_d;
    logic [1:0]    pdm_q, pdm_d;
    logic          pdm_valid_q, pdm_valid_d;
    logic          frame_last_q, frame_last_d;
    logic          overrun_q, overrun_d;

    // Requests folded with what is already pending, so a request arriving in
    // the boundary cycle itself is not lost.
    logic          stop_eff, sel_pend_eff, sel_req_eff;
    logic          sample_now;
    logic          frame_done;

    logic          div_en, pre_rise, pre_fall;

    // The divider is cleared on the same edge that enters IDLE, which is what
    // truncates a high micro_clk when capture ends or is stopped.
    assign div_en = (state_q != IDLE) && (state_d != IDLE);

    pdm_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .micro_clk (micro_clk),
        .pre_rise  (pre_rise),
        .pre_fall  (pre_fall)
    );

    // Left channel drives data on the falling edge, so it is taken just before
    // the rise; right channel is the mirror image.
    assign sample_now = (state_q == CAPTURE) && (sel_lr_q ? pre_fall : pre_rise);

    // The boundary is acted on in the cycle the final sample is presented, so
    // micro_clk/busy/sel_lr change the cycle after frame_last.
    assign frame_done = pdm_valid_q && frame_last_q;

    assign stop_eff     = stop_pend_q | stop;
    assign sel_pend_eff = sel_pend_q  | set_sel_val;
    assign sel_req_eff  = set_sel_val ? set_sel_i : sel_req_q;

    always_comb begin
        state_d      = state_q;
        sel_lr_d     = sel_lr_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        stop_pend_d  = stop_pend_q;
        sel_pend_d   = sel_pend_q;
        sel_req_d    = sel_req_q;
        pdm_d        = pdm_q;
        pdm_valid_d  = 1'b0;
        frame_last_d = 1'b0;
        overrun_d    = overrun_q | (pdm_valid_q & ~pdm_bus.pdm_ready);

        unique case (state_q)
            IDLE: begin
                settle_cnt_d = '0;
                sample_cnt_d = '0;
                stop_pend_d  = 1'b0;
                sel_pend_d   = 1'b0;
                if (set_sel_val) begin
                    sel_lr_d = set_sel_i;
                end
                if (start) begin
                    state_d   = SETTLE;
                    overrun_d = 1'b0;
                end
            end

            SETTLE: begin
                if (set_sel_val) begin
                    sel_lr_d = set_sel_i;
                end
                if (stop) begin
                    state_d      = IDLE;
                    settle_cnt_d = '0;
                end else if (set_sel_val) begin
                    // The mic needs a full settle on the new channel.
                    settle_cnt_d = '0;
                end else if (pre_rise) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d      = CAPTURE;
                        settle_cnt_d = '0;
                        sample_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
            end

            CAPTURE: begin
                stop_pend_d = stop_eff;
                sel_pend_d  = sel_pend_eff;
                sel_req_d   = sel_req_eff;

                if (sample_now) begin
                    pdm_d        = pdm_code(micro_pdm_i);
                    pdm_valid_d  = 1'b1;
                    frame_last_d = (sample_cnt_q == FRAME_LAST);
                    sample_cnt_d = (sample_cnt_q == FRAME_LAST) ? '0
                                                                : sample_cnt_q + FW'(1);
                end

                if (frame_done) begin
                    stop_pend_d = 1'b0;
                    sel_pend_d  = 1'b0;
                    if (stop_eff) begin
                        state_d = IDLE;
                    end else if (sel_pend_eff) begin
                        sel_lr_d     = sel_req_eff;
                        state_d      = SETTLE;
                        settle_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_lr_q     <= 1'b0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            stop_pend_q  <= 1'b0;
            sel_pend_q   <= 1'b0;
            sel_req_q    <= 1'b0;
            pdm_q        <= 2'b00;
            pdm_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_lr_q     <= sel_lr_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            stop_pend_q  <= stop_pend_d;
            sel_pend_q   <= sel_pend_d;
            sel_req_q    <= sel_req_d;
            pdm_q        <= pdm_d;
            pdm_valid_q  <= pdm_valid_d;
            frame_last_q <= frame_last_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pdm_bus.pdm_o      = pdm_q;
    assign pdm_bus.pdm_valid  = pdm_valid_q;
    assign pdm_bus.frame_last = frame_last_q;
    assign sel_lr             = sel_lr_q;
    assign busy               = (state_q != IDLE);
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_capture_ctrl
// Directed bench for pdm_capture_ctrl with CLK_DIV=2, SETTLE_CYC=3,
// FRAME_LEN=4. Each scenario pushes its hand-computed sample stream into a
// scoreboard queue; a monitor pops and compares on every pdm_valid. Cycle
// numbers in the scenarios count clk cycles after the start cycle T.
// Microphone data is pat[k] for the k-th sample of a scenario.
// -----------------------------------------------------------------------------
module tb_pdm_capture_ctrl;

    typedef struct packed {
        logic [1:0] code;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       set_sel_i = 1'b0;
    logic       set_sel_val = 1'b0;
    logic       micro_pdm_i;
    logic       micro_clk, sel_lr, busy, overrun;

    int         checks = 0;
    int         failures = 0;
    int         rx_cnt = 0;
    int         rx_base = 0;
    logic [7:0] pat = 8'h00;
    exp_t       sb_q[$];

    int         first_v, last_v, n_v;

    pdm_capture_ctrl_if bus ();

    pdm_capture_ctrl #(
        .CLK_DIV    (2),
        .SETTLE_CYC (3),
        .FRAME_LEN  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .set_sel_i   (set_sel_i),
        .set_sel_val (set_sel_val),
        .micro_pdm_i (micro_pdm_i),
        .pdm_bus     (bus),
        .micro_clk   (micro_clk),
        .sel_lr      (sel_lr),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Data for sample k of the current scenario; the index only advances
    // after sample k has been presented, well before sample k+1 is taken.
    always @(pat or rx_cnt or rx_base) begin
        micro_pdm_i = pat[(rx_cnt - rx_base) & 7];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] code, input logic last);
        exp_t e;
        e.code = code;
        e.last = last;
        sb_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_micro_clk"}, micro_clk, 0);
        check({tag, "_sel_lr"}, sel_lr, 0);
        check({tag, "_pdm_o"}, bus.pdm_o, 2'b00);
        check({tag, "_pdm_valid"}, bus.pdm_valid, 0);
        check({tag, "_frame_last"}, bus.frame_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (bus.pdm_valid === 1'b1) begin
            check("sb_has_expected", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pdm_o", bus.pdm_o, e.code);
                check("frame_last", bus.frame_last, e.last);
            end
            rx_cnt++;
        end
    end

    task automatic note_valid(input int c);
        if (bus.pdm_valid === 1'b1) begin
            if (first_v < 0) first_v = c;
            last_v = c;
            n_v++;
        end
    endtask

    initial begin
        bus.pdm_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- 1: basic frame, stop at the 2nd sample --------------------------
        rx_base = rx_cnt; pat = 8'b0101_0101;
        push(2'b01, 0); push(2'b11, 0); push(2'b01, 0); push(2'b11, 1);
        first_v = -1; last_v = -1; n_v = 0;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (c == 19);
            note_valid(c);
            if (c == 1) check("t1_busy_T1", busy, 1);
            if (c <= 12) check("t1_micro_clk_wave", micro_clk, ((c - 1) / 2) % 2);
            if (c == 27) begin
                check("t1_mclk_at_last", micro_clk, 1);
                check("t1_busy_at_last", busy, 1);
            end
            if (c == 28) begin
                check("t1_mclk_truncated", micro_clk, 0);
                check("t1_busy_after", busy, 0);
            end
        end
        check("t1_first_valid_cycle", first_v, 15);
        check("t1_last_valid_cycle", last_v, 27);
        check("t1_sample_count", n_v, 4);
        @(negedge clk);

        // ---- 2: channel change to right at sample 1 ---------------------------
        rx_base = rx_cnt; pat = 8'b1100_0101;
        push(2'b01, 0); push(2'b11, 0); push(2'b01, 0); push(2'b11, 1);
        push(2'b11, 0); push(2'b11, 0); push(2'b01, 0); push(2'b01, 1);
        first_v = -1; last_v = -1; n_v = 0;
        start = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            start       = 1'b0;
            set_sel_i   = 1'b1;
            set_sel_val = (c == 15);
            stop        = (c == 45);
            note_valid(c);
            if (c == 27) check("t2_sel_before_boundary", sel_lr, 0);
            if (c == 28) begin
                check("t2_sel_after_boundary", sel_lr, 1);
                check("t2_busy_resettle", busy, 1);
            end
            if (c == 40) check("t2_no_valid_in_resettle", n_v, 4);
            if (c == 41) begin
                check("t2_right_first_valid", bus.pdm_valid, 1);
                check("t2_right_after_fall", micro_clk, 0);
            end
            if (c == 53) check("t2_busy_at_last", busy, 1);
            if (c == 54) begin
                check("t2_busy_after", busy, 0);
                check("t2_mclk_after", micro_clk, 0);
            end
        end
        check("t2_last_valid_cycle", last_v, 53);
        check("t2_sample_count", n_v, 8);
        set_sel_i = 1'b0;
        @(negedge clk);

        // ---- 3: overrun, start+set_sel in IDLE, start while busy --------------
        rx_base = rx_cnt; pat = 8'b0000_1011;
        push(2'b01, 0); push(2'b01, 0); push(2'b11, 0); push(2'b01, 1);
        first_v = -1; last_v = -1; n_v = 0;
        start = 1'b1; set_sel_val = 1'b1; set_sel_i = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start         = (c == 9);
            set_sel_val   = 1'b0;
            stop          = (c == 21);
            bus.pdm_ready = (c != 19);
            note_valid(c);
            if (c == 1) begin
                check("t3_sel_idle_update", sel_lr, 0);
                check("t3_busy_T1", busy, 1);
            end
            if (c == 19) check("t3_overrun_before", overrun, 0);
            if (c == 20) check("t3_overrun_set", overrun, 1);
            if (c == 28) begin
                check("t3_overrun_sticky", overrun, 1);
                check("t3_busy_after", busy, 0);
            end
        end
        check("t3_first_valid_cycle", first_v, 15);
        check("t3_last_valid_cycle", last_v, 27);
        check("t3_sample_count", n_v, 4);
        bus.pdm_ready = 1'b1;
        @(negedge clk);

        // ---- 4: stop during SETTLE; start clears overrun ----------------------
        first_v = -1; last_v = -1; n_v = 0;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (c == 3);
            note_valid(c);
            if (c == 1) check("t4_overrun_cleared", overrun, 0);
            if (c == 3) check("t4_mclk_high_in_settle", micro_clk, 1);
            if (c == 4) begin
                check("t4_busy_after_stop", busy, 0);
                check("t4_mclk_after_stop", micro_clk, 0);
            end
        end
        check("t4_no_samples", n_v, 0);
        @(negedge clk);

        // ---- 5: reset mid-frame with micro_clk high ---------------------------
        set_sel_val = 1'b1; set_sel_i = 1'b1;
        @(negedge clk);
        set_sel_val = 1'b0; set_sel_i = 1'b0;
        check("t5_sel_right", sel_lr, 1);
        rx_base = rx_cnt; pat = 8'b0000_0001;
        push(2'b01, 0); push(2'b11, 0); push(2'b11, 0); push(2'b11, 1);
        first_v = -1; last_v = -1; n_v = 0;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            note_valid(c);
        end
        check("t5_first_valid_cycle", first_v, 13);
        check("t5_mclk_high_before_rst", micro_clk, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rx_base = rx_cnt; pat = 8'b0000_0110;
        push(2'b11, 0); push(2'b01, 0); push(2'b01, 0); push(2'b11, 1);
        first_v = -1; last_v = -1; n_v = 0;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (c == 19);
            note_valid(c);
            if (c == 28) check("t5_busy_after", busy, 0);
        end
        check("t5_fresh_first_valid", first_v, 15);
        check("t5_fresh_last_valid", last_v, 27);
        check("t5_fresh_sample_count", n_v, 4);

        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
